// File: rtl/soc_system_ctrl_regfile.sv
// Avalon-MM control/status register file for the AES core: CTRL with START doorbell,
// live STATUS, W1C interrupt pending bits with enable mask, and general RW words.
module soc_system_ctrl_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_EVENTS = 2
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [ADDR_WIDTH-1:0]                       address,
  input  logic                                        chipselect,
  input  logic                                        read,
  input  logic                                        write,
  input  logic [DATA_WIDTH-1:0]                       writedata,
  input  logic [DATA_WIDTH/8-1:0]                     byteenable,
  output logic [DATA_WIDTH-1:0]                       readdata,
  output logic                                        readdatavalid,
  input  logic [DATA_WIDTH-1:0]                       hw_status,
  input  logic [NUM_EVENTS-1:0]                       hw_event,
  output logic                                        start_pulse,
  output logic                                        irq,
  output logic [(2**ADDR_WIDTH-4)*DATA_WIDTH-1:0]     regs_out
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;
  localparam int NE    = NUM_EVENTS + 1;
  localparam int NG    = DEPTH - 4;

  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [NE-1:0]         r_pend;
  logic [NE-1:0]         r_en;
  logic [DATA_WIDTH-1:0] r_gen [0:NG-1];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdv;
  logic                  r_start_pulse;
  logic                  r_irq;

  logic                  w_wr, w_rd;
  logic                  w_sel_ctrl, w_sel_pend, w_sel_en;
  logic [DATA_WIDTH-1:0] w_bemask;
  logic                  w_start_req, w_start_ok, w_start_rej;
  logic [NE-1:0]         w_clr, w_set, w_pend_next, w_en_next;
  logic [ADDR_WIDTH-1:0] w_gidx;
  logic [DATA_WIDTH-1:0] w_rdata;

  function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                    input logic [DATA_WIDTH-1:0] new_v,
                                                    input logic [DATA_WIDTH-1:0] mask);
    f_merge = (old_v & ~mask) | (new_v & mask);
  endfunction

  // A simultaneous read and write is treated as a write only
  assign w_wr       = chipselect & write;
  assign w_rd       = chipselect & read & ~write;
  assign w_sel_ctrl = w_wr && (address == ADDR_WIDTH'(0));
  assign w_sel_pend = w_wr && (address == ADDR_WIDTH'(2));
  assign w_sel_en   = w_wr && (address == ADDR_WIDTH'(3));
  assign w_gidx     = address - ADDR_WIDTH'(4);

  always_comb begin
    w_bemask = '0;
    for (int k = 0; k < NB; k++) w_bemask[8*k +: 8] = {8{byteenable[k]}};
  end

  assign w_start_req = w_sel_ctrl & byteenable[0] & writedata[0];
  assign w_start_ok  = w_start_req & ~hw_status[0];
  assign w_start_rej = w_start_req &  hw_status[0];

  // Hardware sets are OR'd in after the clear so a colliding set survives the W1C
  assign w_clr       = w_sel_pend ? (writedata[NE-1:0] & w_bemask[NE-1:0]) : '0;
  assign w_set       = {hw_event, w_start_rej};
  assign w_pend_next = (r_pend & ~w_clr) | w_set;
  assign w_en_next   = (r_en & ~w_bemask[NE-1:0]) | (writedata[NE-1:0] & w_bemask[NE-1:0]);

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_WIDTH'(0): w_rdata = r_ctrl;
      ADDR_WIDTH'(1): w_rdata = hw_status;
      ADDR_WIDTH'(2): w_rdata = {{(DATA_WIDTH-NE){1'b0}}, r_pend};
      ADDR_WIDTH'(3): w_rdata = {{(DATA_WIDTH-NE){1'b0}}, r_en};
      default:        w_rdata = r_gen[w_gidx];
    endcase
  end

  // Register stage: state update, read response, doorbell and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl        <= '0;
      r_pend        <= '0;
      r_en          <= '0;
      r_rdata       <= '0;
      r_rdv         <= 1'b0;
      r_start_pulse <= 1'b0;
      r_irq         <= 1'b0;
      for (int g = 0; g < NG; g++) r_gen[g] <= '0;
    end else begin
      r_start_pulse <= w_start_ok;
      r_pend        <= w_pend_next;
      r_irq         <= |(r_pend & r_en);
      r_rdv         <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
      if (w_sel_ctrl) r_ctrl <= f_merge(r_ctrl, writedata, w_bemask) & ~DATA_WIDTH'(1);
      if (w_sel_en) r_en <= w_en_next;
      for (int g = 0; g < NG; g++)
        if (w_wr && (address == ADDR_WIDTH'(g + 4)))
          r_gen[g] <= f_merge(r_gen[g], writedata, w_bemask);
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rdv;
  assign start_pulse   = r_start_pulse;
  assign irq           = r_irq;

  generate
    for (genvar g = 0; g < NG; g++) begin : g_regs_out
      assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = r_gen[g];
    end
  endgenerate

endmodule

// File: tb/tb_soc_system_ctrl_regfile.sv
// Directed bench for soc_system_ctrl_regfile: reset, byte lanes, START doorbell,
// interrupt pending/enable, set-vs-clear collision and pipelined reads.
module tb_soc_system_ctrl_regfile;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   address;
  logic         chipselect, read, write;
  logic [31:0]  writedata;
  logic [3:0]   byteenable;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic [31:0]  hw_status;
  logic [1:0]   hw_event;
  logic         start_pulse, irq;
  logic [383:0] regs_out;

  int n_chk  = 0;
  int n_fail = 0;

  soc_system_ctrl_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_EVENTS(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid), .hw_status(hw_status),
    .hw_event(hw_event), .start_pulse(start_pulse), .irq(irq), .regs_out(regs_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    address = a; writedata = d; byteenable = b; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    chk({tag, "_rdv"}, readdatavalid, 1);
    chk(tag, readdata, exp);
  endtask

  task automatic pulse_evt(input logic [1:0] v);
    @(negedge clk);
    hw_event = v;
    @(negedge clk);
    hw_event = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  pa [3];
    logic [31:0] pe [3];
    reset_n = 1'b0; address = '0; chipselect = 0; read = 0; write = 0;
    writedata = '0; byteenable = '0; hw_status = '0; hw_event = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_start", start_pulse, 0);
    reset_n = 1'b1;

    // 1: reset in the middle of a read with irq asserted
    bus_write(4'd3, 32'h2, 4'hF);
    bus_write(4'd4, 32'hDEADBEEF, 4'hF);
    pulse_evt(2'b01);
    @(negedge clk);
    chk("pre_rst_irq", irq, 1);
    address = 4'd4; chipselect = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_rdv", readdatavalid, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_rdv", readdatavalid, 0);
    chk("midrst_irq", irq, 0);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 16; a++) read_chk($sformatf("rst_word%0d", a), 4'(a), 32'h0);

    // 2: byte lanes
    bus_write(4'd4, 32'hA5A5A5A5, 4'hF);
    bus_write(4'd4, 32'h11223344, 4'b0101);
    chk("be_regs_out", regs_out[31:0], 32'hA522A544);
    read_chk("be_read", 4'd4, 32'hA522A544);
    bus_write(4'd15, 32'h01020304, 4'b1000);
    chk("be_regs_out15", regs_out[383:352], 32'h01000000);

    // 3: START doorbell
    hw_status = 32'h0;
    bus_write(4'd0, 32'h1, 4'hF);
    chk("start_hi", start_pulse, 1);
    @(negedge clk);
    chk("start_lo", start_pulse, 0);
    read_chk("ctrl_read", 4'd0, 32'h0);
    bus_write(4'd0, 32'hF0F1, 4'hE);
    chk("start_be_off", start_pulse, 0);
    read_chk("ctrl_rw", 4'd0, 32'hF000);
    hw_status = 32'h1;
    bus_write(4'd0, 32'h1, 4'hF);
    chk("start_busy", start_pulse, 0);
    read_chk("pend_reject", 4'd2, 32'h1);
    bus_write(4'd2, 32'h1, 4'hF);
    read_chk("pend_clr", 4'd2, 32'h0);
    hw_status = 32'h0;

    // 4: event interrupt
    bus_write(4'd3, 32'h6, 4'hF);
    pulse_evt(2'b10);
    chk("irq_lag", irq, 0);
    @(negedge clk);
    chk("irq_set", irq, 1);
    read_chk("pend_evt1", 4'd2, 32'h4);
    bus_write(4'd2, 32'h4, 4'hF);
    chk("irq_w1c_lag", irq, 1);
    @(negedge clk);
    chk("irq_w1c", irq, 0);
    read_chk("en_read", 4'd3, 32'h6);

    // 5: set and W1C of the same bit in one cycle
    @(negedge clk);
    address = 4'd2; writedata = 32'h2; byteenable = 4'hF; chipselect = 1'b1; write = 1'b1;
    hw_event = 2'b01;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; hw_event = 2'b00;
    read_chk("collide", 4'd2, 32'h2);
    bus_write(4'd2, 32'h2, 4'hF);
    read_chk("collide_clr", 4'd2, 32'h0);

    // 6: back-to-back reads
    bus_write(4'd5, 32'h55AA55AA, 4'hF);
    hw_status = 32'hCAFE0000;
    pa[0] = 4'd1; pa[1] = 4'd3; pa[2] = 4'd5;
    pe[0] = 32'hCAFE0000; pe[1] = 32'h6; pe[2] = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("pipe_rdv%0d", i-1), readdatavalid, 1);
        chk($sformatf("pipe_data%0d", i-1), readdata, pe[i-1]);
      end
      address = pa[i]; chipselect = 1'b1; read = 1'b1;
    end
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    chk("pipe_rdv2", readdatavalid, 1);
    chk("pipe_data2", readdata, pe[2]);
    @(negedge clk);
    chk("pipe_idle_rdv", readdatavalid, 0);
    chk("pipe_hold", readdata, 32'h55AA55AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
